// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the processor's dmem port.
//
// Word-addressed data RAM plus a small MMIO window at MMIO_BASE:
//   +0 LED     R/W   low LED_W bits, reads zero-extended
//   +1 CYCLE   RO    free-running 32-bit rising-edge counter
//   +2 TX_DATA WO    pushes data[7:0] into the TX FIFO, reads 0
//   +3 STATUS  R/W1C {count[7:4], ovf[2], full[1], empty[0]}; write data[2]=1 clears ovf
//   +4 OOB_ADDR RO   first out-of-range address (only with DMEM_BOUNDS_CHECK_EN)
//
// Stores commit on the rising edge. Loads are registered on the falling edge from the
// address presented during the high phase, so q_dmem is stable before the next rising edge.
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN enables the sticky err_oob flag and the
// OOB_ADDR register; without it err_oob is tied 0 and MMIO_BASE+4 is unmapped.
//
// Ports:
//   clock         master clock
//   reset         asynchronous active-low reset
//   address_dmem  word address from the processor
//   data          store data
//   wren          store enable
//   q_dmem        load data (falling-edge registered)
//   led           LED register contents
//   tx_data       TX FIFO head byte (0 when empty)
//   tx_valid      TX FIFO non-empty
//   tx_ready      consumer accepts the head byte
//   err_oob       sticky out-of-range flag
module dmem_responder #(
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned ADDR_BITS  = 12,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_F000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LED_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      address_dmem,
    input  logic [31:0]      data,
    input  logic             wren,
    output logic [31:0]      q_dmem,
    output logic [LED_W-1:0] led,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             err_oob
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [31:0] AddrLed    = MMIO_BASE;
    localparam logic [31:0] AddrCycle  = MMIO_BASE + 32'd1;
    localparam logic [31:0] AddrTx     = MMIO_BASE + 32'd2;
    localparam logic [31:0] AddrStatus = MMIO_BASE + 32'd3;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                 in_ram;
    logic                 sel_led;
    logic                 sel_cycle;
    logic                 sel_tx;
    logic                 sel_status;
    logic [ADDR_BITS-1:0] ram_idx;

    assign in_ram     = address_dmem < 32'(DEPTH);
    assign sel_led    = address_dmem == AddrLed;
    assign sel_cycle  = address_dmem == AddrCycle;
    assign sel_tx     = address_dmem == AddrTx;
    assign sel_status = address_dmem == AddrStatus;
    assign ram_idx    = address_dmem[ADDR_BITS-1:0];

    // ------------------------------------------------------------------
    // Data RAM (contents are not reset)
    // ------------------------------------------------------------------
    logic [31:0] ram [DEPTH];

    always_ff @(posedge clock) begin
        if (wren && in_ram) begin
            ram[ram_idx] <= data;
        end
    end

    // ------------------------------------------------------------------
    // LED register and cycle counter
    // ------------------------------------------------------------------
    logic [LED_W-1:0] led_q;
    logic [31:0]      cycle_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_q   <= '0;
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (wren && sel_led) begin
                led_q <= data[LED_W-1:0];
            end
        end
    end

    assign led = led_q;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push_req;
    logic            push;

    assign fifo_empty = count_q == '0;
    assign fifo_full  = count_q == CntW'(FIFO_DEPTH);
    assign pop        = !fifo_empty && tx_ready;
    assign push_req   = wren && sel_tx;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push       = push_req && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // A fresh overflow beats a simultaneous W1C clear.
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end else if (wren && sel_status && data[2]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= data[7:0];
        end
    end

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

    logic [31:0] status_word;

    always_comb begin
        status_word      = '0;
        status_word[7:4] = 4'(count_q);
        status_word[2]   = ovf_q;
        status_word[1]   = fifo_full;
        status_word[0]   = fifo_empty;
    end

    // ------------------------------------------------------------------
    // Optional bounds checking
    // ------------------------------------------------------------------
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [31:0] AddrOob = MMIO_BASE + 32'd4;

    logic        sel_oob;
    logic        oob_hit;
    logic        oob_clr;
    logic        err_q, err_d;
    logic [31:0] oob_addr_q, oob_addr_d;

    assign sel_oob = address_dmem == AddrOob;
    // Every cycle presents an address, so any unmapped address counts as an access.
    assign oob_hit = !(in_ram || sel_led || sel_cycle || sel_tx || sel_status || sel_oob);
    assign oob_clr = wren && sel_oob;

    always_comb begin
        err_d      = err_q;
        oob_addr_d = oob_addr_q;
        if (oob_hit) begin
            err_d = 1'b1;
            // Latch only the first offender; a clear on this edge re-arms the latch.
            if (!err_q || oob_clr) begin
                oob_addr_d = address_dmem;
            end
        end else if (oob_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q      <= 1'b0;
            oob_addr_q <= '0;
        end else begin
            err_q      <= err_d;
            oob_addr_q <= oob_addr_d;
        end
    end

    assign err_oob = err_q;
`else
    assign err_oob = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Load path: combinational select, captured on the falling edge
    // ------------------------------------------------------------------
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (in_ram) begin
            rdata = ram[ram_idx];
        end else if (sel_led) begin
            rdata = 32'(led_q);
        end else if (sel_cycle) begin
            rdata = cycle_q;
        end else if (sel_status) begin
            rdata = status_word;
        end
`ifdef DMEM_BOUNDS_CHECK_EN
        else if (sel_oob) begin
            rdata = oob_addr_q;
        end
`endif
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            q_dmem <= '0;
        end else begin
            q_dmem <= rdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a stimulus process drives one access per cycle and
// pushes expectations from a queue/array reference model; monitor processes compare on
// the falling edge, when the load data and FIFO outputs are stable.
module tb_dmem_responder;

    localparam logic [31:0] RAM_WORDS = 32'd4096;
    localparam logic [31:0] MB        = 32'h0000_F000;
    localparam int          FD        = 8;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [7:0]  led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        err_oob;

    dmem_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .led          (led),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .err_oob      (err_oob)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model state ----------------
    logic [31:0] m_ram [logic [31:0]];
    logic [7:0]  m_led;
    logic [31:0] m_cyc;
    logic [7:0]  mq [$];
    logic        m_ovf;
    logic        m_err;
    logic [31:0] m_oob_addr;

    typedef struct {
        logic [31:0] q;
        logic [7:0]  led;
        logic        err;
        logic        valid;
        logic [7:0]  txd;
    } exp_t;

    exp_t       exp_q [$];
    string      nm_q [$];
    logic [7:0] exp_tx [$];
    logic       chk_rd;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic mapped(input logic [31:0] a);
        return (a < RAM_WORDS) || (a >= MB && a <= MB + 32'd4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] st;
        if (a < RAM_WORDS) return m_ram.exists(a) ? m_ram[a] : 32'h0;
        if (a == MB) return {24'h0, m_led};
        if (a == MB + 32'd1) return m_cyc;
        if (a == MB + 32'd3) begin
            st      = 32'h0;
            st[7:4] = 4'(mq.size());
            st[2]   = m_ovf;
            st[1]   = mq.size() == FD;
            st[0]   = mq.size() == 0;
            return st;
        end
`ifdef DMEM_BOUNDS_CHECK_EN
        if (a == MB + 32'd4) return m_oob_addr;
`endif
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_led      = 8'h0;
        m_cyc      = 32'h0;
        mq.delete();
        exp_tx.delete();
        m_ovf      = 1'b0;
        m_err      = 1'b0;
        m_oob_addr = 32'h0;
    endtask

    // One bus cycle: called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic rdy, input logic chk, input string nm);
        exp_t       e;
        logic       pop;
        logic       ovf_set;
        logic       ovf_clr;
        logic [7:0] b;
`ifdef DMEM_BOUNDS_CHECK_EN
        logic       oob;
        logic       oclr;
`endif
        address_dmem = a;
        data         = d;
        wren         = w;
        tx_ready     = rdy;
        if (chk) begin
            e.q     = model_read(a);
            e.led   = m_led;
            e.err   = m_err;
            e.valid = mq.size() > 0;
            e.txd   = (mq.size() > 0) ? mq[0] : 8'h00;
            exp_q.push_back(e);
            nm_q.push_back(nm);
        end
        chk_rd = chk;
        pop = rdy && (mq.size() > 0);
        if (pop) exp_tx.push_back(mq[0]);

        @(posedge clock);
        #1;
        chk_rd = 1'b0;

        m_cyc = m_cyc + 32'd1;
        if (w && a < RAM_WORDS) m_ram[a] = d;
        if (w && a == MB) m_led = d[7:0];
        ovf_set = 1'b0;
        ovf_clr = w && (a == MB + 32'd3) && d[2];
        if (pop) b = mq.pop_front();
        if (w && a == MB + 32'd2) begin
            if (mq.size() < FD) mq.push_back(d[7:0]);
            else ovf_set = 1'b1;
        end
        m_ovf = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
`ifdef DMEM_BOUNDS_CHECK_EN
        oob  = !mapped(a);
        oclr = w && (a == MB + 32'd4);
        if (oob && (!m_err || oclr)) m_oob_addr = a;
        m_err = oob ? 1'b1 : (oclr ? 1'b0 : m_err);
`endif
    endtask

    // ---------------- monitors ----------------
    exp_t       mon_e;
    string      mon_nm;
    logic [7:0] mon_b;

    always @(negedge clock) begin
        #1;
        if (reset && chk_rd) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: read strobe with no expectation queued");
            end else begin
                mon_e  = exp_q.pop_front();
                mon_nm = nm_q.pop_front();
                check({mon_nm, ".q_dmem"}, q_dmem, mon_e.q);
                check({mon_nm, ".led"}, {24'h0, led}, {24'h0, mon_e.led});
                check({mon_nm, ".err_oob"}, {31'h0, err_oob}, {31'h0, mon_e.err});
                check({mon_nm, ".tx_valid"}, {31'h0, tx_valid}, {31'h0, mon_e.valid});
                check({mon_nm, ".tx_data"}, {24'h0, tx_data}, {24'h0, mon_e.txd});
            end
        end
        if (reset && tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_pop: unexpected byte %h", tx_data);
            end else begin
                mon_b = exp_tx.pop_front();
                check("tx_pop", {24'h0, tx_data}, {24'h0, mon_b});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          sel;
        int          idx;

        reset        = 1'b0;
        address_dmem = 32'h0;
        data         = 32'h0;
        wren         = 1'b0;
        tx_ready     = 1'b0;
        chk_rd       = 1'b0;
        model_reset();

        #2;
        check("reset.q_dmem", q_dmem, 32'h0);
        check("reset.led", {24'h0, led}, 32'h0);
        check("reset.tx_valid", {31'h0, tx_valid}, 32'h0);
        check("reset.tx_data", {24'h0, tx_data}, 32'h0);
        check("reset.err_oob", {31'h0, err_oob}, 32'h0);

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();

        // Seed the RAM words the random phase will read.
        for (int i = 0; i < 16; i++) step(32'(i), $urandom, 1'b1, 1'b0, 1'b0, "init");
        step(RAM_WORDS - 32'd1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, "init");

        // RAM store then load, plus the top word.
        step(32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, "wr5");
        step(32'd5, 32'h0, 1'b0, 1'b0, 1'b1, "ram5");
        step(RAM_WORDS - 32'd1, 32'h0, 1'b0, 1'b0, 1'b1, "ram_top");

        // LED and cycle counter.
        step(MB, 32'h1A5, 1'b1, 1'b0, 1'b0, "led_wr");
        step(MB, 32'h0, 1'b0, 1'b0, 1'b1, "led_rd");
        step(MB + 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, "cycle_a");
        for (int i = 0; i < 9; i++) step(32'd0, 32'h0, 1'b0, 1'b0, 1'b0, "idle");
        step(MB + 32'd1, 32'h0, 1'b0, 1'b0, 1'b1, "cycle_b");

        // Overflow: nine pushes into an undrained FIFO.
        for (int i = 1; i <= 9; i++) step(MB + 32'd2, 32'(i), 1'b1, 1'b0, 1'b0, "push");
        step(MB + 32'd3, 32'h0, 1'b0, 1'b0, 1'b1, "status_full");
        step(MB + 32'd2, 32'h0, 1'b0, 1'b0, 1'b1, "tx_reads_zero");
        for (int i = 0; i < 8; i++) step(MB + 32'd3, 32'h0, 1'b0, 1'b1, 1'b1, "drain");
        step(MB + 32'd3, 32'h0, 1'b0, 1'b0, 1'b1, "status_empty");
        step(MB + 32'd3, 32'h4, 1'b1, 1'b0, 1'b0, "ovf_clr");

        // Push into a full FIFO while the head leaves.
        for (int i = 0; i < 8; i++) step(MB + 32'd2, 32'h10 + 32'(i), 1'b1, 1'b0, 1'b0, "fill");
        step(MB + 32'd2, 32'h55, 1'b1, 1'b1, 1'b1, "push_pop_full");
        step(MB + 32'd3, 32'h0, 1'b0, 1'b0, 1'b1, "status_pp");
        for (int i = 0; i < 8; i++) step(MB + 32'd3, 32'h0, 1'b0, 1'b1, 1'b1, "drain2");

        // Unmapped read, OOB latch and clear.
        step(32'h0000_2000, 32'h0, 1'b0, 1'b0, 1'b1, "unmapped");
        step(MB + 32'd4, 32'h0, 1'b0, 1'b0, 1'b1, "oob_addr");
        step(MB + 32'd4, 32'h1234, 1'b1, 1'b0, 1'b0, "oob_clr");
        step(32'd5, 32'h0, 1'b0, 1'b0, 1'b1, "after_clr");

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 11);
            d   = $urandom;
            case (sel)
                0, 1, 2, 3: begin
                    idx = $urandom_range(0, 16);
                    a   = (idx == 16) ? RAM_WORDS - 32'd1 : 32'(idx);
                end
                4:       a = MB;
                5:       a = MB + 32'd1;
                6, 7, 8: a = MB + 32'd2;
                9:       a = MB + 32'd3;
                10:      a = MB + 32'd4;
                default: begin
                    idx = $urandom_range(0, 2);
                    a   = (idx == 0) ? 32'h0000_2000 : ((idx == 1) ? MB + 32'd5 : RAM_WORDS);
                end
            endcase
            step(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, "rand");
        end

        // Asynchronous reset with bytes queued and LEDs lit.
        for (int i = 0; i <= FD; i++) step(32'd0, 32'h0, 1'b0, 1'b1, 1'b0, "flush");
        for (int i = 0; i < 3; i++) step(MB + 32'd2, 32'hC0 + 32'(i), 1'b1, 1'b0, 1'b0, "q3");
        step(MB, 32'hFF, 1'b1, 1'b0, 1'b0, "led_ff");
        step(MB, 32'h0, 1'b0, 1'b0, 1'b1, "led_ff_rd");
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst.tx_valid", {31'h0, tx_valid}, 32'h0);
        check("async_rst.tx_data", {24'h0, tx_data}, 32'h0);
        check("async_rst.led", {24'h0, led}, 32'h0);
        check("async_rst.q_dmem", q_dmem, 32'h0);
        check("async_rst.err_oob", {31'h0, err_oob}, 32'h0);
        model_reset();
        address_dmem = 32'h0;
        wren         = 1'b0;
        tx_ready     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // RAM survives reset; FIFO and status restart clean.
        step(32'd5, 32'h0, 1'b0, 1'b0, 1'b1, "ram_keep");
        step(MB + 32'd3, 32'h0, 1'b0, 1'b1, 1'b1, "status_post_rst");
        step(MB + 32'd1, 32'h0, 1'b0, 1'b0, 1'b1, "cycle_post_rst");
        step(32'd0, 32'h0, 1'b0, 1'b0, 1'b0, "idle");

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        check("tx_expect_drained", 32'(exp_tx.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
